// File: rtl/star_collector_pkg.sv
// Shared game_calc definitions: FSM encoding, scoring constants and default timings.
// Helper converts a same-cycle collect count into a BCD score increment.
package star_collector_pkg;

  typedef enum logic [1:0] {
    ST_PLAY     = 2'd0,
    ST_WIN_HOLD = 2'd1,
    ST_DONE     = 2'd2
  } game_state_e;

  localparam logic [15:0] PTS_PER_STAR_BCD = 16'h0100;
  localparam int          DEF_CHIME_CYCLES = 2500000;
  localparam int          DEF_WIN_CYCLES   = 100000000;

  // n * PTS_PER_STAR_BCD in BCD; a star is worth exactly one hundreds unit.
  function automatic logic [15:0] stars_to_pts(input logic [7:0] n);
    logic [7:0] tens;
    logic [7:0] ones;
    tens = n / 8'd10;
    ones = n % 8'd10;
    if (n > 8'd99) begin
      return 16'h9999;
    end
    return {tens[3:0], ones[3:0], PTS_PER_STAR_BCD[7:0]};
  endfunction

endpackage

// File: rtl/star_collector_if.sv
// Star inputs, round control and score/status outputs of the star collector.
// master = game logic / bench side, slave = star_collector.
interface star_collector_if #(
  parameter int NUM_STARS = 8
);
  logic [NUM_STARS-1:0] star_en;
  logic                 round_restart;
  logic [7:0]           star_count;
  logic [15:0]          score_bcd;
  logic [NUM_STARS-1:0] collected_mask;
  logic                 chime;
  logic                 win;
  logic                 round_done;

  modport master (
    output star_en, round_restart,
    input  star_count, score_bcd, collected_mask, chime, win, round_done
  );

  modport slave (
    input  star_en, round_restart,
    output star_count, score_bcd, collected_mask, chime, win, round_done
  );
endinterface

// File: rtl/star_collector_bcd_add4.sv
// 4-digit BCD adder with per-digit carry; saturates to 9999 on overflow.
// Purely combinational, no handshake.
module bcd_add4 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o
);
  logic       carry;
  logic [4:0] dig;

  always_comb begin
    sum_o = '0;
    carry = 1'b0;
    dig   = '0;
    for (int i = 0; i < 4; i++) begin
      dig = {1'b0, a_i[4*i +: 4]} + {1'b0, b_i[4*i +: 4]} + {4'b0, carry};
      if (dig > 5'd9) begin
        dig   = dig + 5'd6;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum_o[4*i +: 4] = dig[3:0];
    end
    if (carry) begin
      sum_o = 16'h9999;
    end
  end
endmodule

// File: rtl/star_collector.sv
// Credits 1->0 star_en falls once per round, keeps BCD score, chime pulse and win FSM.
// Outputs registered, one cycle after the sampled fall; no backpressure (always accepts).
module star_collector
  import star_collector_pkg::*;
#(
  parameter int NUM_STARS    = 8,
  parameter int CHIME_CYCLES = DEF_CHIME_CYCLES,
  parameter int WIN_CYCLES   = DEF_WIN_CYCLES
) (
  input  logic             sys_clk,
  input  logic             RST_N,
  star_collector_if.slave  bus
);
  localparam int CW = (CHIME_CYCLES > 1) ? $clog2(CHIME_CYCLES) : 1;
  localparam int WW = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam logic [CW-1:0] CHIME_LOAD = CW'(CHIME_CYCLES - 1);
  localparam logic [WW-1:0] WIN_LOAD   = WW'(WIN_CYCLES - 1);

  game_state_e          state_q;
  logic [7:0]           star_count_q, star_count_d;
  logic [15:0]          score_q, score_d, pts_add;
  logic [NUM_STARS-1:0] mask_q, mask_d, prev_en_q, events;
  logic [7:0]           n_ev;
  logic [8:0]           count_sum;
  logic [CW-1:0]        chime_cnt_q;
  logic [WW-1:0]        win_cnt_q;
  logic                 chime_q, win_q, done_q, armed_q;

  // armed_q blocks crediting on the first edge after reset, which only samples star_en.
  always_comb begin
    events = '0;
    n_ev   = '0;
    if (armed_q && (state_q == ST_PLAY) && !bus.round_restart) begin
      events = prev_en_q & ~bus.star_en & ~mask_q;
    end
    for (int i = 0; i < NUM_STARS; i++) begin
      n_ev = n_ev + {7'b0, events[i]};
    end
  end

  assign pts_add      = stars_to_pts(n_ev);
  assign count_sum    = {1'b0, star_count_q} + {1'b0, n_ev};
  assign star_count_d = count_sum[8] ? 8'hFF : count_sum[7:0];
  assign mask_d       = mask_q | events;

  bcd_add4 u_bcd_add4 (
    .a_i   (score_q),
    .b_i   (pts_add),
    .sum_o (score_d)
  );

  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_PLAY;
      star_count_q <= '0;
      score_q      <= '0;
      mask_q       <= '0;
      prev_en_q    <= '1;
      chime_cnt_q  <= '0;
      chime_q      <= 1'b0;
      win_cnt_q    <= '0;
      win_q        <= 1'b0;
      done_q       <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      armed_q   <= 1'b1;
      prev_en_q <= bus.star_en;
      if (bus.round_restart) begin
        state_q      <= ST_PLAY;
        star_count_q <= '0;
        score_q      <= '0;
        mask_q       <= '0;
        chime_cnt_q  <= '0;
        chime_q      <= 1'b0;
        win_cnt_q    <= '0;
        win_q        <= 1'b0;
        done_q       <= 1'b0;
      end else begin
        star_count_q <= star_count_d;
        score_q      <= score_d;
        mask_q       <= mask_d;
        if (|events) begin
          chime_cnt_q <= CHIME_LOAD;
          chime_q     <= 1'b1;
        end else begin
          chime_q <= (chime_cnt_q != '0);
          if (chime_cnt_q != '0) chime_cnt_q <= chime_cnt_q - 1'b1;
        end
        case (state_q)
          ST_PLAY: begin
            if (&mask_d) begin
              state_q   <= ST_WIN_HOLD;
              win_q     <= 1'b1;
              win_cnt_q <= WIN_LOAD;
            end
          end
          ST_WIN_HOLD: begin
            if (win_cnt_q == '0) begin
              state_q <= ST_DONE;
              win_q   <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              win_cnt_q <= win_cnt_q - 1'b1;
            end
          end
          ST_DONE: ;
          default: begin
            state_q <= ST_PLAY;
            win_q   <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.star_count     = star_count_q;
  assign bus.score_bcd      = score_q;
  assign bus.collected_mask = mask_q;
  assign bus.chime          = chime_q;
  assign bus.win            = win_q;
  assign bus.round_done     = done_q;

endmodule

// File: tb/tb_star_collector.sv
// Table-driven scoreboard bench for star_collector with short chime/win timings.
module tb_star_collector;
  localparam int NS = 8;
  localparam int CH = 4;
  localparam int WN = 6;

  logic sys_clk = 1'b0;
  logic RST_N   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  star_collector_if #(.NUM_STARS(NS)) bif ();

  star_collector #(
    .NUM_STARS    (NS),
    .CHIME_CYCLES (CH),
    .WIN_CYCLES   (WN)
  ) dut (
    .sys_clk (sys_clk),
    .RST_N   (RST_N),
    .bus     (bif)
  );

  logic [15:0] ba, bb, bs;
  bcd_add4 u_bcd (.a_i(ba), .b_i(bb), .sum_o(bs));

  typedef struct {
    logic [7:0]  en;
    logic        rr;
    logic [7:0]  cnt;
    logic [15:0] score;
    logic [7:0]  mask;
    logic        chime;
    logic        win;
    logic        done;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic [7:0] en, input logic rr, input logic [7:0] c,
                              input logic [15:0] s, input logic [7:0] m,
                              input logic ch, input logic w, input logic d);
    vec_t v;
    v.en = en; v.rr = rr; v.cnt = c; v.score = s; v.mask = m;
    v.chime = ch; v.win = w; v.done = d;
    return v;
  endfunction

  task automatic cmp(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic check_out(input vec_t e, input int row);
    cmp("star_count", row, {8'h00, bif.star_count}, {8'h00, e.cnt});
    cmp("score_bcd", row, bif.score_bcd, e.score);
    cmp("collected_mask", row, {8'h00, bif.collected_mask}, {8'h00, e.mask});
    cmp("chime", row, {15'h0, bif.chime}, {15'h0, e.chime});
    cmp("win", row, {15'h0, bif.win}, {15'h0, e.win});
    cmp("round_done", row, {15'h0, bif.round_done}, {15'h0, e.done});
  endtask

  // Called at a falling edge: drive, push expectation, clock, pop and compare.
  task automatic step(input vec_t v, input int row);
    vec_t e;
    bif.star_en       = v.en;
    bif.round_restart = v.rr;
    exp_q.push_back(v);
    @(posedge sys_clk);
    @(negedge sys_clk);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard row %0d: got empty queue expected entry", row);
    end else begin
      e = exp_q.pop_front();
      check_out(e, row);
    end
  endtask

  task automatic bcd_chk(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp, input int row);
    ba = a;
    bb = b;
    #1;
    cmp("bcd_add4", row, bs, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.star_en       = 8'hFF;
    bif.round_restart = 1'b0;
    RST_N             = 1'b0;
    ba                = '0;
    bb                = '0;
    #12;
    check_out(mk(8'hFF, 0, 8'd0, 16'h0000, 8'h00, 0, 0, 0), -1);

    vecs.push_back(mk(8'hFF, 0, 8'd0, 16'h0000, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'hF7, 0, 8'd1, 16'h0100, 8'h08, 1, 0, 0));
    vecs.push_back(mk(8'hF7, 0, 8'd1, 16'h0100, 8'h08, 1, 0, 0));
    vecs.push_back(mk(8'hF7, 0, 8'd1, 16'h0100, 8'h08, 1, 0, 0));
    vecs.push_back(mk(8'hF7, 0, 8'd1, 16'h0100, 8'h08, 1, 0, 0));
    vecs.push_back(mk(8'hF7, 0, 8'd1, 16'h0100, 8'h08, 0, 0, 0));
    vecs.push_back(mk(8'h96, 0, 8'd4, 16'h0400, 8'h69, 1, 0, 0));
    vecs.push_back(mk(8'h96, 0, 8'd4, 16'h0400, 8'h69, 1, 0, 0));
    vecs.push_back(mk(8'h9E, 0, 8'd4, 16'h0400, 8'h69, 1, 0, 0));
    vecs.push_back(mk(8'h96, 0, 8'd4, 16'h0400, 8'h69, 1, 0, 0));
    vecs.push_back(mk(8'h96, 0, 8'd4, 16'h0400, 8'h69, 0, 0, 0));
    vecs.push_back(mk(8'h94, 0, 8'd5, 16'h0500, 8'h6B, 1, 0, 0));
    vecs.push_back(mk(8'h94, 0, 8'd5, 16'h0500, 8'h6B, 1, 0, 0));
    vecs.push_back(mk(8'h84, 0, 8'd6, 16'h0600, 8'h7B, 1, 0, 0));
    vecs.push_back(mk(8'h84, 0, 8'd6, 16'h0600, 8'h7B, 1, 0, 0));
    vecs.push_back(mk(8'h84, 0, 8'd6, 16'h0600, 8'h7B, 1, 0, 0));
    vecs.push_back(mk(8'h84, 0, 8'd6, 16'h0600, 8'h7B, 1, 0, 0));
    vecs.push_back(mk(8'h84, 0, 8'd6, 16'h0600, 8'h7B, 0, 0, 0));
    vecs.push_back(mk(8'h80, 0, 8'd7, 16'h0700, 8'h7F, 1, 0, 0));
    vecs.push_back(mk(8'h00, 0, 8'd8, 16'h0800, 8'hFF, 1, 1, 0));
    vecs.push_back(mk(8'h00, 0, 8'd8, 16'h0800, 8'hFF, 1, 1, 0));
    vecs.push_back(mk(8'h00, 0, 8'd8, 16'h0800, 8'hFF, 1, 1, 0));
    vecs.push_back(mk(8'h00, 0, 8'd8, 16'h0800, 8'hFF, 1, 1, 0));
    vecs.push_back(mk(8'h00, 0, 8'd8, 16'h0800, 8'hFF, 0, 1, 0));
    vecs.push_back(mk(8'h00, 0, 8'd8, 16'h0800, 8'hFF, 0, 1, 0));
    vecs.push_back(mk(8'h00, 0, 8'd8, 16'h0800, 8'hFF, 0, 0, 1));
    vecs.push_back(mk(8'hFF, 0, 8'd8, 16'h0800, 8'hFF, 0, 0, 1));
    vecs.push_back(mk(8'hFE, 0, 8'd8, 16'h0800, 8'hFF, 0, 0, 1));
    vecs.push_back(mk(8'hFF, 1, 8'd0, 16'h0000, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'hE0, 0, 8'd5, 16'h0500, 8'h1F, 1, 0, 0));
    vecs.push_back(mk(8'hA0, 1, 8'd0, 16'h0000, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'hA0, 0, 8'd0, 16'h0000, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'h20, 0, 8'd1, 16'h0100, 8'h80, 1, 0, 0));

    @(negedge sys_clk);
    RST_N = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], i);
    end

    // Asynchronous reset while the chime is sounding.
    #2 RST_N = 1'b0;
    #1 check_out(mk(8'h20, 0, 8'd0, 16'h0000, 8'h00, 0, 0, 0), 200);

    @(negedge sys_clk);
    bif.star_en = 8'hFF;
    RST_N       = 1'b1;
    step(mk(8'hFF, 0, 8'd0, 16'h0000, 8'h00, 0, 0, 0), 100);
    step(mk(8'h00, 0, 8'd8, 16'h0800, 8'hFF, 1, 1, 0), 101);
    step(mk(8'h00, 0, 8'd8, 16'h0800, 8'hFF, 1, 1, 0), 102);

    // Asynchronous reset in the middle of the win hold.
    #2 RST_N = 1'b0;
    #1 check_out(mk(8'h00, 0, 8'd0, 16'h0000, 8'h00, 0, 0, 0), 201);
    @(negedge sys_clk);
    RST_N = 1'b1;

    bcd_chk(16'h4567, 16'h1234, 16'h5801, 300);
    bcd_chk(16'h0950, 16'h0100, 16'h1050, 301);
    bcd_chk(16'h0999, 16'h0001, 16'h1000, 302);
    bcd_chk(16'h9900, 16'h0100, 16'h9999, 303);
    bcd_chk(16'h9999, 16'h0800, 16'h9999, 304);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
